// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream receive port and instruction-memory write port
// of the loader, bundled as one interface.
//   rx_data/rx_valid/rx_ready : valid/ready byte stream into the loader
//   imem_we/imem_waddr/imem_wdata : word write port toward instruction memory
//   imem_rdata : combinational read-back at imem_waddr (IMEM_LOADER_READBACK_EN only)
// master = loader side, slave = byte source / memory side.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [31:0]           imem_wdata;
`ifdef IMEM_LOADER_READBACK_EN
  logic [31:0]           imem_rdata;

  modport master (
    input  rx_data, rx_valid, imem_rdata,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );
  modport slave (
    output rx_data, rx_valid, imem_rdata,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );
`else
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_waddr, imem_wdata
  );
  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_waddr, imem_wdata
  );
`endif
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image (MAGIC, CNT_LO, CNT_HI,
// CNT*4 little-endian data bytes, CHK) and writes it word by word into
// instruction memory from address 0, holding the core while loading.
//   clk, res  : clock, synchronous active-high reset
//   bus       : imem_loader_if.master (byte stream in, imem write port out)
//   cpu_hold  : core reset request while loading or after a rejected image
//   load_done : sticky, last image loaded and checksum verified
//   load_err  : sticky, last image rejected
// Optional macro IMEM_LOADER_READBACK_EN: verify each written word through
// bus.imem_rdata the cycle after the write (one stall cycle per word).
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [7:0]  MAGIC      = 8'hA5
) (
  input  logic           clk,
  input  logic           res,
  imem_loader_if.master  bus,
  output logic           cpu_hold,
  output logic           load_done,
  output logic           load_err
);

  localparam int unsigned WORD_AW  = ADDR_WIDTH - 2;
  localparam logic [16:0] CAPACITY = 17'(1) << WORD_AW;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CHK, S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_lo_q, cnt_lo_d;
  logic [15:0]           words_left_q, words_left_d;
  logic [1:0]            lane_q, lane_d;
  logic [23:0]           asm_q, asm_d;
  logic [7:0]            chk_q, chk_d;
  logic [WORD_AW-1:0]    waddr_q, waddr_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] imem_waddr_q, imem_waddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic [16:0]           count;
`ifdef IMEM_LOADER_READBACK_EN
  logic                  cmp_q, cmp_d;
`endif

  assign accept         = bus.rx_valid & rx_ready_q;
  assign count          = {1'b0, bus.rx_data, cnt_lo_q};
  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = imem_waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_hold       = hold_q;
  assign load_done      = done_q;
  assign load_err       = err_q;

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_lo_d     = cnt_lo_q;
    words_left_d = words_left_q;
    lane_d       = lane_q;
    asm_d        = asm_q;
    chk_d        = chk_q;
    waddr_d      = waddr_q;
    rx_ready_d   = 1'b1;
    we_d         = 1'b0;
    imem_waddr_d = imem_waddr_q;
    wdata_d      = wdata_q;
    hold_d       = hold_q;
    done_d       = done_q;
    err_d        = err_q;
`ifdef IMEM_LOADER_READBACK_EN
    cmp_d        = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_ERR: begin
        if (accept && bus.rx_data == MAGIC) begin
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          waddr_d = '0;
          chk_d   = '0;
          lane_d  = '0;
          state_d = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (accept) begin
          cnt_lo_d = bus.rx_data;
          chk_d    = chk_q ^ bus.rx_data;
          state_d  = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          chk_d = chk_q ^ bus.rx_data;
          if (count > CAPACITY) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else if (count == 17'd0) begin
            state_d = S_CHK;
          end else begin
            words_left_d = count[15:0];
            lane_d       = '0;
            state_d      = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_d  = chk_q ^ bus.rx_data;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: asm_d[7:0]   = bus.rx_data;
            2'd1: asm_d[15:8]  = bus.rx_data;
            2'd2: asm_d[23:16] = bus.rx_data;
            default: begin
              // Fourth byte completes the word: issue the write next cycle
              we_d         = 1'b1;
              wdata_d      = {bus.rx_data, asm_q};
              imem_waddr_d = {waddr_q, 2'b00};
              waddr_d      = waddr_q + WORD_AW'(1);
              words_left_d = words_left_q - 16'd1;
              if (words_left_q == 16'd1) state_d = S_CHK;
            end
          endcase
        end
      end
      S_CHK: begin
        if (accept) begin
          if (bus.rx_data == chk_q) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef IMEM_LOADER_READBACK_EN
    // Stall one cycle after each write to compare; also keep CHK from
    // being accepted before the last word has been verified.
    if (we_q) begin
      cmp_d      = 1'b1;
      rx_ready_d = 1'b0;
    end
    if (we_d && state_d == S_CHK) rx_ready_d = 1'b0;
    if (cmp_q && bus.imem_rdata != wdata_q) begin
      state_d = S_ERR;
      err_d   = 1'b1;
      hold_d  = 1'b1;
      done_d  = 1'b0;
      we_d    = 1'b0;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= S_IDLE;
      cnt_lo_q     <= '0;
      words_left_q <= '0;
      lane_q       <= '0;
      asm_q        <= '0;
      chk_q        <= '0;
      waddr_q      <= '0;
      rx_ready_q   <= 1'b1;
      we_q         <= 1'b0;
      imem_waddr_q <= '0;
      wdata_q      <= '0;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef IMEM_LOADER_READBACK_EN
      cmp_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_lo_q     <= cnt_lo_d;
      words_left_q <= words_left_d;
      lane_q       <= lane_d;
      asm_q        <= asm_d;
      chk_q        <= chk_d;
      waddr_q      <= waddr_d;
      rx_ready_q   <= rx_ready_d;
      we_q         <= we_d;
      imem_waddr_q <= imem_waddr_d;
      wdata_q      <= wdata_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef IMEM_LOADER_READBACK_EN
      cmp_q        <= cmp_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives framed images into imem_loader and checks the
// resulting memory writes and status flags against frame-level expectations.
module tb_imem_loader;

  localparam int unsigned AW    = 8;
  localparam int unsigned WORDS = 64;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic cpu_hold, load_done, load_err;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .MAGIC(8'hA5)) dut (
    .clk       (clk),
    .res       (res),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

`ifdef IMEM_LOADER_READBACK_EN
  logic [31:0] mem [WORDS];
  always @(posedge clk) if (bus.imem_we) mem[bus.imem_waddr[AW-1:2]] <= bus.imem_wdata;
  assign bus.imem_rdata = mem[bus.imem_waddr[AW-1:2]];
`endif

  int n_checks = 0;
  int n_errors = 0;
  int ready_drops = 0;
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write and handshake monitor
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      obs_addr.push_back(32'(bus.imem_waddr));
      obs_data.push_back(bus.imem_wdata);
    end
    if (!res && bus.rx_ready === 1'b0) ready_drops++;
  end

  // mode 0: full rate, 1: one idle cycle before each byte, 2: random gaps
  task automatic send_byte(input logic [7:0] b, input int mode);
    int gap;
    gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
    for (int g = 0; g < gap; g++) begin
      bus.rx_valid = 1'b0;
      @(negedge clk);
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int t = 0; t < 50 && bus.rx_ready !== 1'b1; t++) @(negedge clk);
    if (bus.rx_ready !== 1'b1) check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] junk_byte();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'hA5) b = 8'h5A;
    return b;
  endfunction

  // Send one frame and check writes and status.
  // corrupt: send wrong CHK. Oversize counts stop after the count bytes.
  task automatic load_frame(input int junk, input int cnt, input bit corrupt,
                            input bit fixed, input int mode);
    logic [31:0] words[$];
    logic [7:0]  bytes[$];
    logic [7:0]  x;
    bit          oversize;
    int          exp_w;
    oversize = (cnt > WORDS);
    for (int j = 0; j < junk; j++) bytes.push_back(junk_byte());
    bytes.push_back(8'hA5);
    bytes.push_back(8'(cnt));
    bytes.push_back(8'(cnt >> 8));
    x = 8'(cnt) ^ 8'(cnt >> 8);
    if (!oversize) begin
      for (int w = 0; w < cnt; w++) begin
        if (fixed) words.push_back(w == 0 ? 32'h0050_0013 : 32'h0000_02B7);
        else       words.push_back($urandom);
        for (int k = 0; k < 4; k++) begin
          bytes.push_back(8'(words[w] >> (8 * k)));
          x ^= 8'(words[w] >> (8 * k));
        end
      end
      bytes.push_back(corrupt ? (x ^ 8'h01) : x);
    end
    obs_addr.delete();
    obs_data.delete();
    foreach (bytes[i]) begin
      send_byte(bytes[i], mode);
      if (i == junk + 2 && !oversize) begin
        check("hold_while_loading", 32'(cpu_hold), 32'd1);
        check("done_clear_while_loading", 32'(load_done), 32'd0);
      end
    end
    idle(4);
    exp_w = oversize ? 0 : cnt;
    check("write_count", 32'(obs_addr.size()), 32'(exp_w));
    for (int w = 0; w < exp_w && w < obs_addr.size(); w++) begin
      check("write_addr", obs_addr[w], 32'(4 * w));
      check("write_data", obs_data[w], words[w]);
    end
    check("load_done", 32'(load_done), 32'(!oversize && !corrupt));
    check("load_err",  32'(load_err),  32'(oversize || corrupt));
    check("cpu_hold",  32'(cpu_hold),  32'(oversize || corrupt));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    check({tag, "_we"},       32'(bus.imem_we), 32'd0);
    check({tag, "_waddr"},    32'(bus.imem_waddr), 32'd0);
    check({tag, "_wdata"},    bus.imem_wdata, 32'd0);
    check({tag, "_hold"},     32'(cpu_hold), 32'd0);
    check({tag, "_done"},     32'(load_done), 32'd0);
    check({tag, "_err"},      32'(load_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    res = 1'b1;
    repeat (3) @(negedge clk);
    res = 1'b0;
    check_reset_state("reset");

    // Known two-word image, full rate
    load_frame(0, 2, 1'b0, 1'b1, 0);
    // Same image with a bad checksum, then a good one clears the error
    load_frame(0, 2, 1'b1, 1'b1, 0);
    load_frame(0, 2, 1'b0, 1'b1, 0);
    // Count one beyond capacity, and exactly at capacity
    load_frame(0, WORDS + 1, 1'b0, 1'b0, 0);
    load_frame(0, WORDS, 1'b0, 1'b0, 0);
    // Leading junk, empty image
    load_frame(3, 0, 1'b0, 1'b0, 0);
    // Half-rate valid during data
    load_frame(0, 2, 1'b0, 1'b1, 1);

    // Reset after the fifth data byte of a two-word frame
    begin
      logic [7:0] hdr [8];
      hdr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'hB7};
      obs_addr.delete();
      obs_data.delete();
      foreach (hdr[i]) send_byte(hdr[i], 0);
      bus.rx_valid = 1'b0;
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      check_reset_state("midload_reset");
      idle(4);
      check("midload_write_count", 32'(obs_addr.size()), 32'd1);
      if (obs_addr.size() > 0) begin
        check("midload_write_addr", obs_addr[0], 32'd0);
        check("midload_write_data", obs_data[0], 32'h0050_0013);
      end
    end

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      int kind;
      int cnt;
      kind = int'($urandom_range(0, 9));
      cnt  = (kind == 0) ? int'($urandom_range(WORDS + 1, 300)) : int'($urandom_range(0, 12));
      load_frame(int'($urandom_range(0, 3)), cnt, kind == 1, 1'b0, int'($urandom_range(0, 2)));
    end

`ifndef IMEM_LOADER_READBACK_EN
    check("rx_ready_never_dropped", 32'(ready_drops), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
